// File: rtl/karatsuba_pkg.sv
// Shared constants and types for the karatsuba multiplier datapath.
// Blocks such as e_factor and the D-factor import widths from here.
package karatsuba_pkg;

    // Default operand half width; the full operand is twice this.
    localparam int HALF_W = 4;
    localparam int FULL_W = 2 * HALF_W;
    localparam int SUM_W  = HALF_W + 1;

    typedef logic [HALF_W-1:0] half_t;
    typedef logic [FULL_W-1:0] full_t;
    typedef logic [SUM_W-1:0]  sum_t;

endpackage : karatsuba_pkg

// File: rtl/e_rca_adder.sv
// Parameterized ripple-carry adder: sum = a + b with the carry-out kept in the
// MSB of sum. Purely combinational, built from one full adder per bit.
module e_rca_adder #(
    parameter int HALF_W = karatsuba_pkg::HALF_W
) (
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [HALF_W:0]   sum
);

    // carry[0] is the adder's carry-in (tied low); carry[HALF_W] is the carry-out.
    logic [HALF_W:0] carry;

    assign carry[0] = 1'b0;

    // One full adder per bit; the carry ripples from LSB to MSB.
    for (genvar gi = 0; gi < HALF_W; gi++) begin : g_fa
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign sum[HALF_W] = carry[HALF_W];

endmodule : e_rca_adder

// File: rtl/e_factor.sv
// Karatsuba E factor: splits Y into high half C and low half D and registers
// E = C + D (carry kept) one cycle after a valid input.
// Optional feature macro: E_FACTOR_ZERO_FLAG_EN adds a registered e_zero flag
// that is high when the value loaded into E is zero.
module e_factor
    import karatsuba_pkg::*;
#(
    parameter int HALF_W = karatsuba_pkg::HALF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [2*HALF_W-1:0]   Y,
    output logic                  out_valid,
    output logic [HALF_W:0]       E
`ifdef E_FACTOR_ZERO_FLAG_EN
    ,
    output logic                  e_zero
`endif
);

    logic [HALF_W-1:0] c_half;
    logic [HALF_W-1:0] d_half;
    logic [HALF_W:0]   sum_next;
    logic [HALF_W:0]   e_reg;
    logic              out_valid_reg;

    assign c_half = Y[2*HALF_W-1:HALF_W];
    assign d_half = Y[HALF_W-1:0];

    e_rca_adder #(
        .HALF_W (HALF_W)
    ) u_adder (
        .a   (c_half),
        .b   (d_half),
        .sum (sum_next)
    );

    // Result register: loads only on valid so a don't-care Y never reaches E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_reg <= '0;
        end else if (in_valid) begin
            e_reg <= sum_next;
        end
    end

    // Valid tracks the input one cycle later; no bubbles, no backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
        end
    end

    assign E         = e_reg;
    assign out_valid = out_valid_reg;

`ifdef E_FACTOR_ZERO_FLAG_EN
    logic e_zero_reg;

    // Zero flag follows E: starts at 1 (E resets to 0), updates with each load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_zero_reg <= 1'b1;
        end else if (in_valid) begin
            e_zero_reg <= (sum_next == '0);
        end
    end

    assign e_zero = e_zero_reg;
`endif

endmodule : e_factor

// File: tb/tb_e_factor.sv
// Self-checking bench for e_factor. Expected values come from plain arithmetic
// on Y (high half plus low half) and a small model of the register state.
module tb_e_factor;

    localparam int HW = 4;
    localparam int FW = 2 * HW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [FW-1:0] Y;
    logic          out_valid;
    logic [HW:0]   E;
`ifdef E_FACTOR_ZERO_FLAG_EN
    logic          e_zero;
`endif

    int n_checks;
    int n_fail;

    // model state
    int exp_e;
    int exp_v;
    int exp_z;

    e_factor #(.HALF_W(HW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Y         (Y),
        .out_valid (out_valid),
        .E         (E)
`ifdef E_FACTOR_ZERO_FLAG_EN
        ,
        .e_zero    (e_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_sum(input int y);
        return (y / (1 << HW)) + (y % (1 << HW));
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle after the rising edge.
    task automatic drive(input logic v, input logic [FW-1:0] y);
        @(negedge clk);
        in_valid = v;
        Y        = y;
        @(posedge clk);
        #1;
        if (rst_n) begin
            exp_v = v ? 1 : 0;
            if (v) begin
                exp_e = model_sum(int'(y));
                exp_z = (exp_e == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        Y        = 8'hFF;
        exp_e = 0; exp_v = 0; exp_z = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (E !== 5'd0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: E=%b out_valid=%b expected E=00000 out_valid=0", E, out_valid);
            end
`ifdef E_FACTOR_ZERO_FLAG_EN
            n_checks++;
            if (e_zero !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_zero: e_zero=%b expected 1", e_zero);
            end
`endif
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (E !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: E=%b out_valid=%b expected E=00000 out_valid=0", E, out_valid);
        end
        $display("reset: E=%b out_valid=%b", E, out_valid);
    endtask

    task automatic test_basic();
        logic [FW-1:0] ys [2];
        logic [HW:0]   es [2];
        ys[0] = 8'b01100101; es[0] = 5'b01011;
        ys[1] = 8'b11100000; es[1] = 5'b01110;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ys[i]);
            n_checks++;
            if (E !== es[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_%0d: Y=%h E=%b out_valid=%b expected E=%b out_valid=1", i, ys[i], E, out_valid, es[i]);
            end
            $display("basic: Y=%h E=%b out_valid=%b", ys[i], E, out_valid);
        end
    endtask

    task automatic test_carry();
        logic [FW-1:0] ys [3];
        logic [HW:0]   es [3];
        ys[0] = 8'b10100111; es[0] = 5'b10001;
        ys[1] = 8'hFF;       es[1] = 5'b11110;
        ys[2] = 8'h00;       es[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ys[i]);
            n_checks++;
            if (E !== es[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL carry_%0d: Y=%h E=%b out_valid=%b expected E=%b out_valid=1", i, ys[i], E, out_valid, es[i]);
            end
`ifdef E_FACTOR_ZERO_FLAG_EN
            n_checks++;
            if (e_zero !== (es[i] == 5'd0)) begin
                n_fail++;
                $display("FAIL carry_zero_%0d: e_zero=%b expected %b", i, e_zero, (es[i] == 5'd0));
            end
`endif
            $display("carry: Y=%h E=%b out_valid=%b", ys[i], E, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] ys [3];
        logic [HW:0]   es [3];
        ys[0] = 8'h65; es[0] = 5'b01011;
        ys[1] = 8'hE0; es[1] = 5'b01110;
        ys[2] = 8'hA7; es[2] = 5'b10001;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ys[i]);
            n_checks++;
            if (E !== es[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: Y=%h E=%b out_valid=%b expected E=%b out_valid=1", i, ys[i], E, out_valid, es[i]);
            end
            $display("stream: Y=%h E=%b out_valid=%b", ys[i], E, out_valid);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 8'hA7);
        drive(1'b0, 8'h11);
        n_checks++;
        if (E !== 5'b10001 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: E=%b out_valid=%b expected E=10001 out_valid=0", E, out_valid);
        end
        drive(1'b0, 'x);
        n_checks++;
        if (E !== 5'b10001 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_x: E=%b out_valid=%b expected E=10001 out_valid=0", E, out_valid);
        end
        $display("hold: E=%b out_valid=%b", E, out_valid);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hA7);
        n_checks++;
        if (E !== 5'b10001) begin
            n_fail++;
            $display("FAIL async_pre: E=%b expected 10001", E);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (E !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: E=%b out_valid=%b expected E=00000 out_valid=0", E, out_valid);
        end
`ifdef E_FACTOR_ZERO_FLAG_EN
        n_checks++;
        if (e_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL async_zero: e_zero=%b expected 1", e_zero);
        end
`endif
        $display("async_reset: E=%b out_valid=%b", E, out_valid);
        exp_e = 0; exp_v = 0; exp_z = 1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_exhaustive();
        int errs_before;
        errs_before = n_fail;
        for (int y = 0; y < (1 << FW); y++) begin
            drive(1'b1, FW'(y));
            n_checks++;
            if (int'(E) !== model_sum(y) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep: Y=%h E=%0d out_valid=%b expected E=%0d out_valid=1", y[FW-1:0], E, out_valid, model_sum(y));
            end
        end
        $display("sweep: %0d values, %0d new failures", 1 << FW, n_fail - errs_before);
    endtask

    task automatic test_random();
        logic          v;
        logic [FW-1:0] y;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            y = FW'($urandom);
            drive(v, y);
            n_checks++;
            if (int'(E) !== exp_e || int'(out_valid) !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: v=%b Y=%h E=%0d out_valid=%b expected E=%0d out_valid=%0d", i, v, y, E, out_valid, exp_e, exp_v);
            end
`ifdef E_FACTOR_ZERO_FLAG_EN
            n_checks++;
            if (int'(e_zero) !== exp_z) begin
                n_fail++;
                $display("FAIL random_zero_%0d: e_zero=%b expected %0d", i, e_zero, exp_z);
            end
`endif
            $display("random: v=%b Y=%h E=%b out_valid=%b", v, y, E, out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_e_factor
